// File: rtl/kbd_ps2_matrix.sv
// PS/2 set-2 keyboard receiver mapped onto the 8x5 ZX Spectrum key matrix.
// Optional macro KBD_PS2_PARITY_CHECK_EN enables odd-parity checking of each frame.
module kbd_ps2_matrix (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic [7:0] a_hi,
  output logic [4:0] kd,
  output logic       key_reset,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  rx_state_t   state, state_nxt;
  logic [1:0]  clk_sync, dat_sync;
  logic        clk_prev;
  logic        fall, dat_s;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [15:0] tcnt;
  logic        byte_ok, rx_err, par_ok;

  logic        ext, brk, ctrl, alt;
  logic [2:0]  skip_cnt;
  logic [39:0] matrix;
  logic [39:0] key_mask;
  logic        is_ctrl, is_alt, is_del;
  logic [4:0]  row_or;

  assign fall  = clk_prev & ~clk_sync[1];
  assign dat_s = dat_sync[1];

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      clk_prev <= clk_sync[1];
    end
  end

`ifdef KBD_PS2_PARITY_CHECK_EN
  logic par_bit;
  assign par_ok = ^{shreg, par_bit};
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    byte_ok   = 1'b0;
    rx_err    = 1'b0;
    if (fall) begin
      case (state)
        IDLE:    if (!dat_s) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP: begin
          state_nxt = IDLE;
          if (dat_s && par_ok) byte_ok = 1'b1;
          else                 rx_err  = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (state != IDLE && tcnt == 16'hFFFF) begin
      state_nxt = IDLE;
      rx_err    = 1'b1;
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      tcnt      <= '0;
      frame_err <= 1'b0;
`ifdef KBD_PS2_PARITY_CHECK_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      frame_err <= rx_err;
      if (fall) begin
        tcnt <= '0;
        case (state)
          IDLE: bit_cnt <= '0;
          DATA: begin
            shreg   <= {dat_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
`ifdef KBD_PS2_PARITY_CHECK_EN
          PARITY: par_bit <= dat_s;
`endif
          default: ;
        endcase
      end else if (tcnt != 16'hFFFF) begin
        tcnt <= tcnt + 16'd1;
      end
    end
  end

  // Matrix bit index = row*5 + column; compound keys set two bits.
  always_comb begin
    key_mask = '0;
    is_ctrl  = (shreg == 8'h14);
    is_alt   = (shreg == 8'h11);
    is_del   = (shreg == 8'h71);
    case ({ext, shreg})
      9'h012: key_mask[0]  = 1'b1;
      9'h01A: key_mask[1]  = 1'b1;
      9'h022: key_mask[2]  = 1'b1;
      9'h021: key_mask[3]  = 1'b1;
      9'h02A: key_mask[4]  = 1'b1;
      9'h01C: key_mask[5]  = 1'b1;
      9'h01B: key_mask[6]  = 1'b1;
      9'h023: key_mask[7]  = 1'b1;
      9'h02B: key_mask[8]  = 1'b1;
      9'h034: key_mask[9]  = 1'b1;
      9'h015: key_mask[10] = 1'b1;
      9'h01D: key_mask[11] = 1'b1;
      9'h024: key_mask[12] = 1'b1;
      9'h02D: key_mask[13] = 1'b1;
      9'h02C: key_mask[14] = 1'b1;
      9'h016: key_mask[15] = 1'b1;
      9'h01E: key_mask[16] = 1'b1;
      9'h026: key_mask[17] = 1'b1;
      9'h025: key_mask[18] = 1'b1;
      9'h02E: key_mask[19] = 1'b1;
      9'h045: key_mask[20] = 1'b1;
      9'h046: key_mask[21] = 1'b1;
      9'h03E: key_mask[22] = 1'b1;
      9'h03D: key_mask[23] = 1'b1;
      9'h036: key_mask[24] = 1'b1;
      9'h04D: key_mask[25] = 1'b1;
      9'h044: key_mask[26] = 1'b1;
      9'h043: key_mask[27] = 1'b1;
      9'h03C: key_mask[28] = 1'b1;
      9'h035: key_mask[29] = 1'b1;
      9'h05A: key_mask[30] = 1'b1;
      9'h04B: key_mask[31] = 1'b1;
      9'h042: key_mask[32] = 1'b1;
      9'h03B: key_mask[33] = 1'b1;
      9'h033: key_mask[34] = 1'b1;
      9'h029: key_mask[35] = 1'b1;
      9'h059: key_mask[36] = 1'b1;
      9'h03A: key_mask[37] = 1'b1;
      9'h031: key_mask[38] = 1'b1;
      9'h032: key_mask[39] = 1'b1;
      9'h066: begin key_mask[0] = 1'b1; key_mask[20] = 1'b1; end
      9'h16B: begin key_mask[0] = 1'b1; key_mask[19] = 1'b1; end
      9'h172: begin key_mask[0] = 1'b1; key_mask[24] = 1'b1; end
      9'h175: begin key_mask[0] = 1'b1; key_mask[23] = 1'b1; end
      9'h174: begin key_mask[0] = 1'b1; key_mask[22] = 1'b1; end
      default: ;
    endcase
  end

  // A compound release clears CS outright, even while Left Shift is held.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      ext       <= 1'b0;
      brk       <= 1'b0;
      ctrl      <= 1'b0;
      alt       <= 1'b0;
      skip_cnt  <= '0;
      matrix    <= '0;
      key_reset <= 1'b0;
    end else begin
      key_reset <= 1'b0;
      if (byte_ok) begin
        if (skip_cnt != 3'd0) begin
          skip_cnt <= skip_cnt - 3'd1;
        end else if (shreg == 8'hE1) begin
          skip_cnt <= 3'd7;
        end else if (shreg == 8'hE0) begin
          ext <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (is_ctrl) ctrl <= ~brk;
          if (is_alt)  alt  <= ~brk;
          if (is_del && !brk && ctrl && alt) key_reset <= 1'b1;
          matrix <= brk ? (matrix & ~key_mask) : (matrix | key_mask);
        end
      end
    end
  end

  always_comb begin
    row_or = '0;
    for (int unsigned r = 0; r < 8; r++)
      if (!a_hi[r]) row_or = row_or | matrix[r*5 +: 5];
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) kd <= '1;
    else        kd <= ~row_or;
  end

endmodule

// File: tb/tb_kbd_ps2_matrix.sv
// Directed bench for kbd_ps2_matrix: PS/2 frames in, ZX matrix columns and pulses out.
module tb_kbd_ps2_matrix;

  logic       clk28 = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] a_hi = 8'hFF;
  logic [4:0] kd;
  logic       key_reset;
  logic       frame_err;

  int tests = 0;
  int failed = 0;
  int ferr_cnt = 0;
  int krst_cnt = 0;

  localparam int HALF = 10;

  kbd_ps2_matrix dut (
    .clk28     (clk28),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .a_hi      (a_hi),
    .kd        (kd),
    .key_reset (key_reset),
    .frame_err (frame_err)
  );

  always #5 clk28 = ~clk28;

  always @(negedge clk28) begin
    if (frame_err) ferr_cnt++;
    if (key_reset) krst_cnt++;
  end

  task automatic ps2_bit(input logic b);
    @(negedge clk28) ps2_dat = b;
    repeat (HALF) @(negedge clk28);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk28);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit((~^d) ^ par_flip);
    ps2_bit(stop);
    repeat (8) @(negedge clk28);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, 1'b0, 1'b1);
  endtask

  // Change a_hi and sample kd exactly one rising edge later.
  task automatic probe(input logic [7:0] a);
    @(negedge clk28) a_hi = a;
    @(negedge clk28);
  endtask

  task automatic test_reset;
    a_hi = 8'h00;
    repeat (3) @(negedge clk28);
    tests++; if (kd !== 5'b11111) begin failed++; $display("FAIL reset_kd kd=%b exp=11111", kd); end
    tests++; if (key_reset !== 1'b0) begin failed++; $display("FAIL reset_key_reset got=%b exp=0", key_reset); end
    tests++; if (frame_err !== 1'b0) begin failed++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk28);
  endtask

  task automatic test_press;
    send_byte(8'h1C);
    probe(8'hFD);
    tests++; if (kd !== 5'b11110) begin failed++; $display("FAIL press_a_row kd=%b exp=11110", kd); end
    probe(8'hFE);
    tests++; if (kd !== 5'b11111) begin failed++; $display("FAIL press_a_other_row kd=%b exp=11111", kd); end
  endtask

  task automatic test_release_and_compound;
    send_byte(8'hF0); send_byte(8'h1C);
    probe(8'hFD);
    tests++; if (kd !== 5'b11111) begin failed++; $display("FAIL release_a kd=%b exp=11111", kd); end
    send_byte(8'hE0); send_byte(8'h75);
    probe(8'hFE);
    tests++; if (kd !== 5'b11110) begin failed++; $display("FAIL up_cs kd=%b exp=11110", kd); end
    probe(8'hEF);
    tests++; if (kd !== 5'b10111) begin failed++; $display("FAIL up_7 kd=%b exp=10111", kd); end
  endtask

  task automatic test_ghost_shift;
    send_byte(8'h12);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    probe(8'hFE);
    tests++; if (kd !== 5'b11111) begin failed++; $display("FAIL ghost_cs_cleared kd=%b exp=11111", kd); end
    probe(8'hEF);
    tests++; if (kd !== 5'b11111) begin failed++; $display("FAIL ghost_7_cleared kd=%b exp=11111", kd); end
    send_byte(8'hF0); send_byte(8'h12);
  endtask

  task automatic test_backspace;
    send_byte(8'h66);
    probe(8'hFE);
    tests++; if (kd !== 5'b11110) begin failed++; $display("FAIL bksp_cs kd=%b exp=11110", kd); end
    probe(8'hEF);
    tests++; if (kd !== 5'b11110) begin failed++; $display("FAIL bksp_0 kd=%b exp=11110", kd); end
    send_byte(8'hF0); send_byte(8'h66);
    probe(8'h00);
    tests++; if (kd !== 5'b11111) begin failed++; $display("FAIL bksp_release kd=%b exp=11111", kd); end
  endtask

  task automatic test_ctrl_alt_del;
    int k0;
    k0 = krst_cnt;
    send_byte(8'h14); send_byte(8'h11);
    send_byte(8'hE0); send_byte(8'h71);
    tests++; if (krst_cnt !== k0 + 1) begin failed++; $display("FAIL cad_pulse_cycles got=%0d exp=%0d", krst_cnt - k0, 1); end
    probe(8'h00);
    tests++; if (kd !== 5'b11111) begin failed++; $display("FAIL cad_matrix kd=%b exp=11111", kd); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h71);
    send_byte(8'hF0); send_byte(8'h11);
    k0 = krst_cnt;
    send_byte(8'h71);
    tests++; if (krst_cnt !== k0) begin failed++; $display("FAIL cad_without_alt got=%0d exp=0", krst_cnt - k0); end
    send_byte(8'hF0); send_byte(8'h71);
    send_byte(8'hF0); send_byte(8'h14);
  endtask

  task automatic test_timeout;
    int e0;
    int n;
    e0 = ferr_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    n = 0;
    while (n < 70000 && ferr_cnt == e0) begin
      @(negedge clk28);
      n++;
    end
    tests++; if (ferr_cnt !== e0 + 1) begin failed++; $display("FAIL timeout_frame_err got=%0d exp=1", ferr_cnt - e0); end
    tests++; if (n < 65000) begin failed++; $display("FAIL timeout_early cycles=%0d exp>=65000", n); end
    send_byte(8'h29);
    probe(8'h7F);
    tests++; if (kd !== 5'b11110) begin failed++; $display("FAIL after_timeout_space kd=%b exp=11110", kd); end
    send_byte(8'hF0); send_byte(8'h29);
  endtask

  task automatic test_parity;
    int e0;
    e0 = ferr_cnt;
    send_frame(8'h1A, 1'b1, 1'b1);
    probe(8'hFE);
`ifdef KBD_PS2_PARITY_CHECK_EN
    tests++; if (ferr_cnt !== e0 + 1) begin failed++; $display("FAIL parity_frame_err got=%0d exp=1", ferr_cnt - e0); end
    tests++; if (kd !== 5'b11111) begin failed++; $display("FAIL parity_kd kd=%b exp=11111", kd); end
`else
    tests++; if (ferr_cnt !== e0) begin failed++; $display("FAIL parity_frame_err got=%0d exp=0", ferr_cnt - e0); end
    tests++; if (kd !== 5'b11101) begin failed++; $display("FAIL parity_kd kd=%b exp=11101", kd); end
`endif
    send_byte(8'hF0); send_byte(8'h1A);
  endtask

  task automatic test_bad_stop;
    int e0;
    e0 = ferr_cnt;
    send_frame(8'h16, 1'b0, 1'b0);
    tests++; if (ferr_cnt !== e0 + 1) begin failed++; $display("FAIL stop_frame_err got=%0d exp=1", ferr_cnt - e0); end
    probe(8'hF7);
    tests++; if (kd !== 5'b11111) begin failed++; $display("FAIL stop_discard kd=%b exp=11111", kd); end
  endtask

  task automatic test_pause_skip;
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77);
    send_byte(8'hE1); send_byte(8'hF0); send_byte(8'h14);
    send_byte(8'hF0); send_byte(8'h77);
    send_byte(8'h16);
    probe(8'hF7);
    tests++; if (kd !== 5'b11110) begin failed++; $display("FAIL pause_then_1 kd=%b exp=11110", kd); end
    probe(8'h00);
    tests++; if (kd !== 5'b11110) begin failed++; $display("FAIL pause_all_rows kd=%b exp=11110", kd); end
  endtask

  task automatic test_reset_midframe;
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b0);
    @(negedge clk28) rst_n = 1'b0;
    repeat (3) @(negedge clk28);
    rst_n = 1'b1;
    probe(8'h00);
    tests++; if (kd !== 5'b11111) begin failed++; $display("FAIL midreset_cleared kd=%b exp=11111", kd); end
    send_byte(8'h15);
    probe(8'hFB);
    tests++; if (kd !== 5'b11110) begin failed++; $display("FAIL midreset_q kd=%b exp=11110", kd); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_release_and_compound();
    test_ghost_shift();
    test_backspace();
    test_ctrl_alt_del();
    test_timeout();
    test_parity();
    test_bad_stop();
    test_pause_skip();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
